edp_mult_sequencer: RTL

EDP_MULT_SEQUENCER -- requirements
Module: edp_mult_sequencer

---
 rtl/edp_pkg.sv | 26 ++
 rtl/edp_fp_mult_unit.sv | 39 +++
 rtl/edp_mult_sequencer.sv | 136 +++++++++++++
 3 files changed

// File: rtl/edp_pkg.sv
// Shared types and FP32 field positions for the EDP multiply sequencer.
package edp_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam int SIGN_BIT = 31;
    localparam int EXP_MSB  = 30;
    localparam int EXP_LSB  = 23;
    localparam int MANT_MSB = 22;
    localparam int BIAS     = 127;

    localparam int PROD_EXP_W  = 9;
    localparam int PROD_MANT_W = 48;

    typedef struct packed {
        logic                   sign;
        logic [PROD_EXP_W-1:0]  exponent;
        logic [PROD_MANT_W-1:0] mantissa;
    } prod_t;

endpackage

// File: rtl/edp_fp_mult_unit.sv
// Combinational FP32 x FP32 product: sign, unnormalised exponent, exact 48-bit mantissa.
// No rounding or normalisation; denormal inputs contribute an implicit 0 bit.
module edp_fp_mult_unit
    import edp_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic [DATA_WIDTH-1:0] i_a,
    input  logic [DATA_WIDTH-1:0] i_b,
    output prod_t                 o_prod
);

    logic [7:0]            w_exp_a;
    logic [7:0]            w_exp_b;
    logic                  w_zero_a;
    logic                  w_zero_b;
    logic [23:0]           w_mant_a;
    logic [23:0]           w_mant_b;
    logic [PROD_EXP_W-1:0] w_exp_sum;

    assign w_exp_a  = i_a[EXP_MSB:EXP_LSB];
    assign w_exp_b  = i_b[EXP_MSB:EXP_LSB];
    assign w_zero_a = (w_exp_a == 8'd0);
    assign w_zero_b = (w_exp_b == 8'd0);
    assign w_mant_a = {~w_zero_a, i_a[MANT_MSB:0]};
    assign w_mant_b = {~w_zero_b, i_b[MANT_MSB:0]};

    // A zero exponent field means a true exponent of 1-BIAS; the sum wraps modulo 2^PROD_EXP_W.
    assign w_exp_sum = PROD_EXP_W'(w_exp_a) + PROD_EXP_W'(w_exp_b)
                     + PROD_EXP_W'(w_zero_a) + PROD_EXP_W'(w_zero_b)
                     - PROD_EXP_W'(BIAS);

    always_comb begin
        o_prod.sign     = i_a[SIGN_BIT] ^ i_b[SIGN_BIT];
        o_prod.exponent = w_exp_sum;
        o_prod.mantissa = PROD_MANT_W'(w_mant_a) * PROD_MANT_W'(w_mant_b);
    end

endmodule

// File: rtl/edp_mult_sequencer.sv
// Vector job sequencer feeding a 2-stage FP32 multiply pipeline (S1 operands, S2 product).
// Latency 2 cycles, 1 pair/cycle; S2 stalls on !ProdReady, at most 2 pairs held in flight.
module edp_mult_sequencer
    import edp_pkg::*;
#(
    parameter int DATA_WIDTH            = 32,
    parameter int LEN_WIDTH             = 16,
    parameter int RESULT_EXP_WIDTH      = 9,
    parameter int RESULT_MANTISSA_WIDTH = 48
) (
    input  logic                             Clk,
    input  logic                             ResetN,
    input  logic                             Start,
    input  logic [LEN_WIDTH-1:0]             VecLen,
    input  logic                             Abort,
    output logic                             Busy,
    output logic                             Done,
    input  logic                             OpValid,
    output logic                             OpReady,
    input  logic [DATA_WIDTH-1:0]            OpA,
    input  logic [DATA_WIDTH-1:0]            OpB,
    output logic                             ProdValid,
    input  logic                             ProdReady,
    output logic                             ProdSign,
    output logic [RESULT_EXP_WIDTH-1:0]      ProdExponent,
    output logic [RESULT_MANTISSA_WIDTH-1:0] ProdMantissa,
    output logic                             ProdLast
);

    localparam logic [LEN_WIDTH-1:0] LEN_ONE = {{(LEN_WIDTH-1){1'b0}}, 1'b1};

    state_t                r_state;
    state_t                w_next;
    logic [LEN_WIDTH-1:0]  r_len;
    logic [LEN_WIDTH-1:0]  r_iss_cnt;
    logic [LEN_WIDTH-1:0]  r_ret_cnt;
    logic                  r_s1_vld;
    logic [DATA_WIDTH-1:0] r_s1_a;
    logic [DATA_WIDTH-1:0] r_s1_b;
    logic                  r_s2_vld;
    prod_t                 r_s2_prod;
    prod_t                 w_prod;
    logic                  w_abort;
    logic                  w_s2_ld;
    logic                  w_acc;
    logic                  w_ret;
    logic                  w_last;
    logic                  w_iss_done;

    edp_fp_mult_unit #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_mult (
        .i_a    (r_s1_a),
        .i_b    (r_s1_b),
        .o_prod (w_prod)
    );

    assign w_abort    = Abort && (r_state != ST_IDLE);
    assign w_s2_ld    = !r_s2_vld || ProdReady;
    assign w_acc      = OpValid && OpReady;
    assign w_ret      = r_s2_vld && ProdReady;
    assign w_iss_done = (r_iss_cnt == r_len);
    // Products retire in issue order, so the retire index identifies the final one.
    assign w_last     = r_s2_vld && (r_ret_cnt == r_len - LEN_ONE);

    always_ff @(posedge Clk or negedge ResetN) begin
        if (!ResetN) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:  if (Start) w_next = (VecLen == '0) ? ST_DONE : ST_RUN;
            ST_RUN:   if (w_iss_done) w_next = ST_DRAIN;
            ST_DRAIN: if (w_ret && w_last) w_next = ST_DONE;
            ST_DONE:  w_next = ST_IDLE;
            default:  w_next = ST_IDLE;
        endcase
        if (w_abort) w_next = ST_IDLE;
    end

    always_comb begin
        Busy    = (r_state != ST_IDLE);
        Done    = (r_state == ST_DONE);
        OpReady = (r_state == ST_RUN) && (r_iss_cnt < r_len) && (!r_s1_vld || w_s2_ld);
    end

    always_ff @(posedge Clk or negedge ResetN) begin
        if (!ResetN) begin
            r_len     <= '0;
            r_iss_cnt <= '0;
            r_ret_cnt <= '0;
            r_s1_vld  <= 1'b0;
            r_s1_a    <= '0;
            r_s1_b    <= '0;
            r_s2_vld  <= 1'b0;
            r_s2_prod <= '0;
        end else if (w_abort) begin
            r_iss_cnt <= '0;
            r_ret_cnt <= '0;
            r_s1_vld  <= 1'b0;
            r_s2_vld  <= 1'b0;
            r_s2_prod <= '0;
        end else begin
            if (r_state == ST_IDLE && Start) begin
                r_len     <= VecLen;
                r_iss_cnt <= '0;
                r_ret_cnt <= '0;
            end
            if (w_acc) begin
                r_s1_vld  <= 1'b1;
                r_s1_a    <= OpA;
                r_s1_b    <= OpB;
                r_iss_cnt <= r_iss_cnt + LEN_ONE;
            end else if (w_s2_ld) begin
                r_s1_vld  <= 1'b0;
            end
            if (w_s2_ld) begin
                r_s2_vld <= r_s1_vld;
                if (r_s1_vld) r_s2_prod <= w_prod;
            end
            if (w_ret) r_ret_cnt <= r_ret_cnt + LEN_ONE;
        end
    end

    assign ProdValid    = r_s2_vld;
    assign ProdSign     = r_s2_prod.sign;
    assign ProdExponent = RESULT_EXP_WIDTH'(r_s2_prod.exponent);
    assign ProdMantissa = RESULT_MANTISSA_WIDTH'(r_s2_prod.mantissa);
    assign ProdLast     = w_last;

endmodule
